// File: rtl/audio_dc_filter_pkg.sv
// Shared types and constants for the audio DC-blocking filter.
package audio_dcf_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StCalcL,
        StCalcR,
        StEmit
    } dcf_state_t;

    localparam logic [15:0] MIDSCALE = 16'h8000;

    // Galois LFSR, taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Midscale-offset unsigned <-> two's complement is just an MSB flip
    function automatic sample_t to_signed(input logic [15:0] u);
        return {~u[15], u[14:0]};
    endfunction

    function automatic logic [15:0] to_unsigned(input sample_t s);
        return {~s[15], s[14:0]};
    endfunction

endpackage

// File: rtl/audio_dc_filter_if.sv
// Sample-stream interface between the audio core, the DC filter and the compressor.
interface audio_dc_filter_if;

    logic        enable;
    logic        bypass;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        sample_stb;

    modport master (
        output enable, bypass, in_l, in_r,
        input  out_l, out_r, sample_stb
    );

    modport slave (
        input  enable, bypass, in_l, in_r,
        output out_l, out_r, sample_stb
    );

endinterface

// File: rtl/audio_tick_gen.sv
// Drift-free fractional sample-rate tick generator (phase accumulator).
module audio_tick_gen #(
    parameter int unsigned CLK_RATE    = 28000000,
    parameter int unsigned SAMPLE_RATE = 48000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    logic [31:0] acc_q, acc_d;
    logic [32:0] sum;

    assign sum = {1'b0, acc_q} + 33'(SAMPLE_RATE);

    // Advance the accumulator; wrap by CLK_RATE and tick on overflow
    always_comb begin
        tick  = 1'b0;
        acc_d = acc_q;
        if (enable) begin
            if (sum >= 33'(CLK_RATE)) begin
                tick  = 1'b1;
                acc_d = 32'(sum - 33'(CLK_RATE));
            end else begin
                acc_d = sum[31:0];
            end
        end
    end

    // Accumulator register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/audio_dc_filter.sv
// DC-blocking one-pole high-pass filter for stereo 16-bit audio, one shared
// datapath time-multiplexed over L then R.
// Optional build macro AUDIO_DCF_DITHER_EN adds LFSR dither before saturation.
module audio_dc_filter
    import audio_dcf_pkg::*;
#(
    parameter int unsigned CLK_RATE    = 28000000,
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned K_SHIFT     = 10
) (
    input logic              clk_sys,
    input logic              reset_n,
    audio_dc_filter_if.slave aud
);

    localparam int unsigned DW = 16 + K_SHIFT;

    // The FSM needs 5 cycles per sample, so a tick can never land outside IDLE
    if ((CLK_RATE / SAMPLE_RATE) < 8) begin : g_bad_ratio
        $error("audio_dc_filter: CLK_RATE/SAMPLE_RATE must be at least 8");
    end
    if ((K_SHIFT < 4) || (K_SHIFT > 15)) begin : g_bad_kshift
        $error("audio_dc_filter: K_SHIFT must be in 4..15");
    end

    logic tick;

    audio_tick_gen #(
        .CLK_RATE   (CLK_RATE),
        .SAMPLE_RATE(SAMPLE_RATE)
    ) u_tick_gen (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .enable (aud.enable),
        .tick   (tick)
    );

    dcf_state_t           state_q, state_d;
    logic [15:0]          in_l_q, in_r_q;
    logic signed [DW-1:0] dc_l_q, dc_r_q;
    sample_t              y_l_q;
    logic [15:0]          out_l_q, out_r_q;
    logic                 stb_q;

    logic                 sel_r;
    sample_t              x, d_hi, y_filt, y;
    logic signed [DW-1:0] d_cur, d_new;
    logic signed [DW:0]   x_ext, d_ext, err, step, d_sum;
    logic signed [17:0]   y_wide;

`ifdef AUDIO_DCF_DITHER_EN
    logic [15:0]       lfsr_q;
    logic signed [1:0] dith;

    assign dith = sel_r ? lfsr_q[3:2] : lfsr_q[1:0];
`endif

    // Shared filter datapath: output uses the pre-update DC estimate
    always_comb begin
        sel_r  = (state_q == StCalcR);
        x      = to_signed(sel_r ? in_r_q : in_l_q);
        d_cur  = sel_r ? dc_r_q : dc_l_q;
        d_hi   = d_cur[DW-1:K_SHIFT];
        y_wide = {{2{x[15]}}, x} - {{2{d_hi[15]}}, d_hi};
`ifdef AUDIO_DCF_DITHER_EN
        y_wide = y_wide + {{16{dith[1]}}, dith};
`endif
        if (y_wide > 18'sd32767) begin
            y_filt = 16'sh7FFF;
        end else if (y_wide < -18'sd32768) begin
            y_filt = 16'sh8000;
        end else begin
            y_filt = y_wide[15:0];
        end
        y     = aud.bypass ? x : y_filt;
        // d += ((x << K) - d) >>> K, one guard bit so the error cannot wrap
        x_ext = {x[15], x, {K_SHIFT{1'b0}}};
        d_ext = {d_cur[DW-1], d_cur};
        err   = x_ext - d_ext;
        step  = err >>> K_SHIFT;
        d_sum = d_ext + step;
        d_new = d_sum[DW-1:0];
    end

    // Sequencer: a tick arriving outside IDLE is simply ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick) state_d = StLatch;
            StLatch: state_d = StCalcL;
            StCalcL: state_d = StCalcR;
            StCalcR: state_d = StEmit;
            StEmit:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Input latch, per-channel DC estimates and the held left result
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            in_l_q <= MIDSCALE;
            in_r_q <= MIDSCALE;
            dc_l_q <= '0;
            dc_r_q <= '0;
            y_l_q  <= '0;
        end else begin
            if (state_q == StLatch) begin
                in_l_q <= aud.in_l;
                in_r_q <= aud.in_r;
            end
            if (state_q == StCalcL) begin
                dc_l_q <= d_new;
                y_l_q  <= y;
            end
            if (state_q == StCalcR) begin
                dc_r_q <= d_new;
            end
        end
    end

    // Outputs load together so they are valid for the whole EMIT cycle with the strobe
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            out_l_q <= MIDSCALE;
            out_r_q <= MIDSCALE;
            stb_q   <= 1'b0;
        end else begin
            stb_q <= (state_q == StCalcR);
            if (state_q == StCalcR) begin
                out_l_q <= to_unsigned(y_l_q);
                out_r_q <= to_unsigned(y);
            end
        end
    end

`ifdef AUDIO_DCF_DITHER_EN
    // Dither source steps once per emitted sample
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (state_q == StEmit) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end
`endif

    assign aud.out_l      = out_l_q;
    assign aud.out_r      = out_r_q;
    assign aud.sample_stb = stb_q;

endmodule

// File: doc/audio_dc_filter.md
Name: audio_dc_filter

Overview:
- DC-blocking stage between the core's 16-bit unsigned stereo audio (audio_left/audio_right) and the downstream compressor.
- Resamples both channels at a fixed audio rate derived from clk_sys.
- Removes DC offset with a one-pole high-pass filter, saturates, and re-emits unsigned midscale-centred samples.
- One shared datapath, time-multiplexed across L and R.

Parameters:
- CLK_RATE, 28000000: clk_sys frequency in Hz.
- SAMPLE_RATE, 48000: output sample rate in Hz. Elaboration error if CLK_RATE/SAMPLE_RATE < 8.
- K_SHIFT, 10: filter pole shift. The DC estimate moves by 2^-K_SHIFT of the error per sample. Legal range 4..15.

Ports:
- clk_sys  in  1  system clock (28 MHz).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = generate sample ticks; 0 = freeze all state and hold outputs.
- bypass  in  1  1 = pass latched input unchanged at the same latency.
- in_l  in  16  left input, unsigned, midscale 16'h8000.
- in_r  in  16  right input, unsigned, midscale 16'h8000.
- out_l  out  16  left output, unsigned.
- out_r  out  16  right output, unsigned.
- sample_stb  out  1  one-cycle pulse in the cycle out_l/out_r update.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - out_l = out_r = 16'h8000; sample_stb = 0.
  - Phase accumulator = 0; both DC estimates = 0; state = IDLE.
  - Reset asserted mid-operation aborts the in-flight sample; nothing partial is emitted.
- Tick generator:
  - 32-bit phase accumulator, advanced only when enable=1.
  - If acc + SAMPLE_RATE >= CLK_RATE: tick=1 and acc <= acc + SAMPLE_RATE - CLK_RATE. Otherwise acc <= acc + SAMPLE_RATE.
  - Exactly SAMPLE_RATE ticks per CLK_RATE enabled cycles, with no drift.
- FSM states: IDLE, LATCH, CALC_L, CALC_R, EMIT.
  - IDLE -> LATCH on tick.
  - LATCH: capture in_l and in_r in the same cycle.
  - CALC_L, CALC_R: filter arithmetic, one channel per cycle.
  - EMIT: register both outputs and pulse sample_stb; then return to IDLE.
  - Latency: sample_stb asserts 4 cycles after the tick cycle.
  - A tick outside IDLE is impossible given the ratio check. If one occurs anyway, it is dropped.
- Arithmetic, per channel:
  - Signed input x = {~in[15], in[14:0]}.
  - DC estimate d is a signed 16+K_SHIFT fixed-point value; d_hi is its top 16 bits.
  - y = x - d_hi, computed in 17 bits and saturated to [-32768, +32767].
  - d <= d + (((x <<< K_SHIFT) - d) >>> K_SHIFT), arithmetic shifts, 17+K_SHIFT-bit intermediate.
  - Output = {~y[15], y[14:0]}.
  - y always uses the pre-update d.
- Bypass:
  - y = x, no filtering.
  - d keeps updating, so releasing bypass causes no large step.
  - Latency and strobe timing are unchanged.
- enable=0 mid-sample: an in-flight sample still completes and emits. After that, no further ticks occur.

Optional Feature:
- Macro: AUDIO_DCF_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per EMIT.
  - LFSR bits [1:0], as a signed value in -2..+1, are added to y of each channel before saturation. L uses bits [1:0], R uses bits [3:2].
  - Not applied in bypass.
- Undefined: no LFSR logic; outputs are exactly as specified above.

Decomposition:
- Package audio_dcf_pkg:
  - typedef sample_t (logic signed [15:0]).
  - enum dcf_state_t.
  - localparam MIDSCALE = 16'h8000.
  - LFSR seed and tap constants.
- Sub-module audio_tick_gen: the phase-accumulator tick generator (clk_sys, reset_n, enable -> tick). Parameterised with CLK_RATE and SAMPLE_RATE.
- Filter datapath stays in the top module, time-multiplexed.

Test Plan:
- Rate: defaults, enable=1 from reset release.
  - First tick on the 584th enabled cycle; first sample_stb 4 cycles later.
  - Exactly 48000 strobes in 28,000,000 cycles.
- Step response: in_l = in_r = 16'hC000 held.
  - First emitted out = 16'hC000.
  - Monotonic decay toward 16'h8000; within ±1 of 16'h8000 after 16384 samples.
- Saturation: in_l = 16'h0001 held for 20000 samples, then 16'hFFFF. The next out_l is 16'hFFFF (clipped, not wrapped).
- Bypass: bypass=1, in_l = 16'h1234, in_r = 16'hFEDC. The outputs equal the inputs exactly, 4 cycles after the tick.
- Reset and freeze:
  - Pull reset_n low during CALC_R: out_l = out_r = 16'h8000 immediately, sample_stb stays 0, and the first post-reset strobe matches the rate test.
  - enable=0 for 10000 cycles: no strobes, outputs held.
- Dither, with AUDIO_DCF_DITHER_EN defined and zero-DC input 16'h8000 settled: outputs stay within 16'h7FFE..16'h8001 and are not constant over 64 samples.
